mult_div_unit: RTL and testbench

//  Iterative multiply/divide responder for the EX stage. It serves MULT, MULTU, DIV and DIVU.
//  EX drives funct and the operands, and holds the pipeline (stall_request = !mult_div_done)

---
 rtl/mult_div_unit_pkg.sv | 33 +++
 rtl/mult_div_unit_step.sv | 36 +++
 rtl/mult_div_unit.sv | 117 +++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - funct codes, op encoding and decode helpers for the multiply/divide unit
package mult_div_unit_pkg;

  localparam int DATA_BUS_W = 32;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  function automatic md_op_e decode_op(input logic [5:0] f);
    md_op_e op;
    case (f)
      FUNCT_MULT: op = OP_MULT;
      FUNCT_DIV:  op = OP_DIV;
      FUNCT_DIVU: op = OP_DIVU;
      default:    op = OP_MULTU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// rtl/mult_div_unit_step.sv - one combinational shift-add (multiply) or restore-subtract (divide) step
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  always_comb begin
    sum       = {1'b0, hi} + {1'b0, (lo[0] ? operand : {WIDTH{1'b0}})};
    rem_shift = {hi, lo[WIDTH-1]};
    trial     = rem_shift - {1'b0, operand};
    hi_next   = hi;
    lo_next   = lo;
    if (!is_div) begin
      // Multiplier bits are consumed from lo[0] while product bits shift in at the top.
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      hi_next = trial[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_next = rem_shift[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU responder for the EX stage
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DATA_BUS_W,
  parameter int ITER  = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           funct,
  input  logic [WIDTH-1:0]     operand_1,
  input  logic [WIDTH-1:0]     operand_2,
  input  logic                 flush,
  input  logic                 stall_in,
  output logic                 mult_div_done,
  output logic [2*WIDTH-1:0]   mult_div_result,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state, next_state;
  md_op_e           op;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] hi, lo, divisor;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [CNT_W-1:0] cnt;

  logic             start, signed_op, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] fixed_result;

  assign start     = is_md_funct(funct);
  assign signed_op = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign neg_a     = signed_op && operand_1[WIDTH-1];
  assign neg_b     = signed_op && operand_2[WIDTH-1];
  assign abs_a     = neg_a ? (~operand_1 + WIDTH'(1)) : operand_1;
  assign abs_b     = neg_b ? (~operand_2 + WIDTH'(1)) : operand_2;

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  ((op == OP_DIV) || (op == OP_DIVU)),
    .hi      (hi),
    .lo      (lo),
    .operand (divisor),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_CALC;
      S_CALC: if (cnt == CNT_LAST) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: if (!stall_in) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (flush) next_state = S_IDLE;
  end

  // Divide: quotient takes sign(a)^sign(b), remainder takes the dividend's sign.
  always_comb begin
    fixed_result = {hi, lo};
    case (op)
      OP_MULT: if (sign_a ^ sign_b) fixed_result = ~{hi, lo} + (2*WIDTH)'(1);
      OP_DIV: begin
        fixed_result[2*WIDTH-1:WIDTH] = sign_a ? (~hi + WIDTH'(1)) : hi;
        fixed_result[WIDTH-1:0]       = (sign_a ^ sign_b) ? (~lo + WIDTH'(1)) : lo;
      end
      default: fixed_result = {hi, lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op              <= OP_MULT;
      sign_a          <= 1'b0;
      sign_b          <= 1'b0;
      hi              <= '0;
      lo              <= '0;
      divisor         <= '0;
      cnt             <= '0;
      mult_div_result <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: if (start) begin
          op      <= decode_op(funct);
          sign_a  <= neg_a;
          sign_b  <= neg_b;
          hi      <= '0;
          lo      <= abs_a;
          divisor <= abs_b;
          cnt     <= '0;
        end
        S_CALC: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: mult_div_result <= fixed_result;
        default: ;
      endcase
    end
  end

  assign mult_div_done = (state == S_DONE);
  assign busy          = (state == S_CALC) || (state == S_FIX);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam int LATENCY = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  funct = 6'h00;
  logic [31:0] operand_1 = '0;
  logic [31:0] operand_2 = '0;
  logic        flush = 1'b0;
  logic        stall_in = 1'b0;
  logic        mult_div_done;
  logic [63:0] mult_div_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_exp = '0;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  mult_div_unit dut (
    .clk             (clk),
    .rst             (rst),
    .funct           (funct),
    .operand_1       (operand_1),
    .operand_2       (operand_2),
    .flush           (flush),
    .stall_in        (stall_in),
    .mult_div_done   (mult_div_done),
    .mult_div_result (mult_div_result),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural results from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return ua * ub;
      F_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) begin
          q = (sa < 0) ? 1 : 64'hFFFF_FFFF;
          return {a, q[31:0]};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        funct = 6'h00;
        check("busy_in_calc", 64'(busy), 64'd1);
      end
      if (mult_div_done) break;
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b;
    wait_done(lat);
    check({name, "_latency"}, 64'(lat), 64'(LATENCY));
    check({name, "_result"}, mult_div_result, exp);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 64'(mult_div_done), 64'd0);
    last_exp = exp;
  endtask

  initial begin
    int lat, dcnt;
    logic [5:0]  rf;
    logic [31:0] ra, rb;

    vecs[0] = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2] = '{F_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[4] = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[5] = '{F_DIVU,  32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF};
    vecs[6] = '{F_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_0000_0001};
    vecs[7] = '{F_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E};
    vecs[8] = '{F_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_done", 64'(mult_div_done), 64'd0);
    check("reset_result", mult_div_result, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Flush in CALC: abort, result held, no done.
    @(negedge clk);
    funct = F_MULTU; operand_1 = 32'h1234; operand_2 = 32'h5678;
    @(negedge clk);
    funct = 6'h00;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(mult_div_done), 64'd0);
    check("flush_result_held", mult_div_result, last_exp);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (mult_div_done) dcnt++;
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    run_op("after_flush", F_MULTU, 32'd3, 32'd4, 64'h0000_0000_0000_000C);

    // Stall at DONE for 3 cycles, then back-to-back op from the following IDLE cycle.
    stall_in = 1'b1;
    @(negedge clk);
    funct = F_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
    wait_done(lat);
    check("stall_latency", 64'(lat), 64'(LATENCY));
    dcnt = mult_div_done ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (mult_div_done) dcnt++;
    end
    stall_in = 1'b0;
    @(negedge clk);
    check("stall_done_cycles", 64'(dcnt), 64'd4);
    check("stall_release", 64'(mult_div_done), 64'd0);
    funct = F_MULTU; operand_1 = 32'd2; operand_2 = 32'd3;
    wait_done(lat);
    check("b2b_latency", 64'(lat), 64'(LATENCY));
    check("b2b_result", mult_div_result, 64'd6);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rf = F_MULT + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) rb = 32'd0;
      if (i % 8 == 3) ra = 32'h8000_0000;
      if (i % 5 == 4) rb = rb >> $urandom_range(16, 31);
      run_op($sformatf("rand%0d", i), rf, ra, rb, model(rf, ra, rb));
    end

    // Reset mid-CALC clears all outputs on the next cycle.
    @(negedge clk);
    funct = F_MULT; operand_1 = 32'hFFFF_0001; operand_2 = 32'h0000_0123;
    @(negedge clk);
    funct = 6'h00;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_done", 64'(mult_div_done), 64'd0);
    check("rst_mid_result", mult_div_result, 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
